// File: rtl/regfile_writeback_if.sv
// Handshake, write-port and read-bypass signals of the register-file write-back buffer.
// master = MEM stage / register-file side, slave = the buffer itself.
interface regfile_writeback_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rd;
  logic          in_reg_write;
  logic          in_mem_to_reg;
  logic [DW-1:0] in_alu_result;
  logic [DW-1:0] in_mem_data;
  logic          hold;
  logic          we3;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd3;
  logic [AW-1:0] a1;
  logic [AW-1:0] a2;
  logic [DW-1:0] rf_rd1;
  logic [DW-1:0] rf_rd2;
  logic [DW-1:0] fwd_rd1;
  logic [DW-1:0] fwd_rd2;
  logic          busy;

  modport slave (
    input  in_valid, in_rd, in_reg_write, in_mem_to_reg, in_alu_result, in_mem_data,
    input  hold, a1, a2, rf_rd1, rf_rd2,
    output in_ready, we3, a3, wd3, fwd_rd1, fwd_rd2, busy
  );

  modport master (
    output in_valid, in_rd, in_reg_write, in_mem_to_reg, in_alu_result, in_mem_data,
    output hold, a1, a2, rf_rd1, rf_rd2,
    input  in_ready, we3, a3, wd3, fwd_rd1, fwd_rd2, busy
  );
endinterface

// File: rtl/regfile_writeback.sv
// Two-entry write-back FIFO in front of the register-file write port, with
// read-side bypass of still-queued results onto both read ports.
module regfile_writeback #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
) (
  input logic                clk,
  input logic                rst,
  regfile_writeback_if.slave bus
);

  typedef struct packed {
    logic          reg_write;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } entry_t;

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  entry_t head;
  entry_t tail;
  entry_t in_entry;
  logic   push;
  logic   pop;
  logic   head_valid;
  logic   tail_valid;

  // Load/ALU select happens at acceptance; only the chosen data is stored.
  always_comb begin
    in_entry.reg_write = bus.in_reg_write;
    in_entry.rd        = bus.in_rd;
    in_entry.data      = bus.in_mem_to_reg ? bus.in_mem_data : bus.in_alu_result;
  end

  assign head_valid   = (state != EMPTY);
  assign tail_valid   = (state == FULL);
  assign bus.in_ready = (state != FULL);
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = head_valid & ~bus.hold;
  assign bus.busy     = head_valid;

  assign bus.we3 = pop & head.reg_write & (head.rd != '0);
  assign bus.a3  = head_valid ? head.rd   : '0;
  assign bus.wd3 = head_valid ? head.data : '0;

  // Newest matching entry wins; x0 always reads as zero.
  function automatic logic [DW-1:0] bypass(
    input logic [AW-1:0] a,
    input logic [DW-1:0] rf,
    input entry_t        hd,
    input logic          hd_valid,
    input entry_t        tl,
    input logic          tl_valid
  );
    if (a == '0)                                      return '0;
    else if (tl_valid && tl.reg_write && tl.rd == a)  return tl.data;
    else if (hd_valid && hd.reg_write && hd.rd == a)  return hd.data;
    else                                              return rf;
  endfunction

  assign bus.fwd_rd1 = bypass(bus.a1, bus.rf_rd1, head, head_valid, tail, tail_valid);
  assign bus.fwd_rd2 = bypass(bus.a2, bus.rf_rd2, head, head_valid, tail, tail_valid);

  // Occupancy FSM; head always holds the oldest entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head  <= in_entry;
            state <= ONE;
          end
        end
        ONE: begin
          if (push && !pop) begin
            tail  <= in_entry;
            state <= FULL;
          end else if (push && pop) begin
            head  <= in_entry;
          end else if (pop) begin
            head  <= '0;
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head  <= tail;
            tail  <= '0;
            state <= ONE;
          end
        end
        default: begin
          state <= EMPTY;
          head  <= '0;
          tail  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed, table-driven check of the write-back buffer plus a mid-operation reset sequence.
module tb_regfile_writeback;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  regfile_writeback_if #(.AW(5), .DW(32)) bus ();

  regfile_writeback #(.AW(5), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic        rw;
    logic        mtr;
    logic [31:0] alu;
    logic [31:0] mem;
    logic        hold;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] rf1;
    logic [31:0] rf2;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic        e_rdy;
    logic        e_busy;
    logic [31:0] e_f1;
    logic [31:0] e_f2;
  } vec_t;

  localparam int unsigned NV = 21;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid      = v.valid;
    bus.in_rd         = v.rd;
    bus.in_reg_write  = v.rw;
    bus.in_mem_to_reg = v.mtr;
    bus.in_alu_result = v.alu;
    bus.in_mem_data   = v.mem;
    bus.hold          = v.hold;
    bus.a1            = v.a1;
    bus.a2            = v.a2;
    bus.rf_rd1        = v.rf1;
    bus.rf_rd2        = v.rf2;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    // valid rd rw mtr alu mem hold a1 a2 rf1 rf2 | we a3 wd rdy busy f1 f2  (checked before the edge)
    tbl[0]  = '{0, 0, 0, 0, 32'h0,    32'h0,        0, 5, 0, 32'h111, 32'h222, 0, 0, 32'h0,        1, 0, 32'h111,      32'h0};
    // single write
    tbl[1]  = '{1, 5, 1, 0, 32'h1234, 32'h5555,     0, 5, 0, 32'h111, 32'h222, 0, 0, 32'h0,        1, 0, 32'h111,      32'h0};
    tbl[2]  = '{0, 0, 0, 0, 32'h0,    32'h0,        0, 5, 0, 32'h111, 32'h222, 1, 5, 32'h1234,     1, 1, 32'h1234,     32'h0};
    // load select
    tbl[3]  = '{1, 7, 1, 1, 32'h1,    32'hDEADBEEF, 0, 7, 0, 32'h777, 32'h222, 0, 0, 32'h0,        1, 0, 32'h777,      32'h0};
    tbl[4]  = '{0, 0, 0, 0, 32'h0,    32'h0,        0, 7, 0, 32'h777, 32'h222, 1, 7, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF, 32'h0};
    tbl[5]  = '{0, 0, 0, 0, 32'h0,    32'h0,        0, 7, 0, 32'h777, 32'h222, 0, 0, 32'h0,        1, 0, 32'h777,      32'h0};
    // full, backpressure, bypass priority
    tbl[6]  = '{1, 3, 1, 0, 32'hAA,   32'h0,        1, 3, 0, 32'h333, 32'h222, 0, 0, 32'h0,        1, 0, 32'h333,      32'h0};
    tbl[7]  = '{1, 3, 1, 0, 32'hBB,   32'h0,        1, 3, 0, 32'h333, 32'h222, 0, 3, 32'hAA,       1, 1, 32'hAA,       32'h0};
    tbl[8]  = '{1, 9, 1, 0, 32'hCC,   32'h0,        1, 3, 0, 32'h333, 32'h222, 0, 3, 32'hAA,       0, 1, 32'hBB,       32'h0};
    tbl[9]  = '{0, 0, 0, 0, 32'h0,    32'h0,        1, 4, 3, 32'h444, 32'h222, 0, 3, 32'hAA,       0, 1, 32'h444,      32'hBB};
    tbl[10] = '{0, 0, 0, 0, 32'h0,    32'h0,        0, 3, 0, 32'h333, 32'h222, 1, 3, 32'hAA,       0, 1, 32'hBB,       32'h0};
    tbl[11] = '{0, 0, 0, 0, 32'h0,    32'h0,        0, 9, 0, 32'h999, 32'h222, 1, 3, 32'hBB,       1, 1, 32'h999,      32'h0};
    tbl[12] = '{0, 0, 0, 0, 32'h0,    32'h0,        0, 3, 0, 32'h333, 32'h222, 0, 0, 32'h0,        1, 0, 32'h333,      32'h0};
    // push and pop together in ONE replaces the head
    tbl[13] = '{1, 1, 1, 0, 32'h11,   32'h0,        0, 2, 0, 32'h200, 32'h222, 0, 0, 32'h0,        1, 0, 32'h200,      32'h0};
    tbl[14] = '{1, 2, 1, 0, 32'h22,   32'h0,        0, 2, 0, 32'h200, 32'h222, 1, 1, 32'h11,       1, 1, 32'h200,      32'h0};
    tbl[15] = '{0, 0, 0, 0, 32'h0,    32'h0,        0, 2, 0, 32'h200, 32'h222, 1, 2, 32'h22,       1, 1, 32'h22,       32'h0};
    // x0 and no-write entries
    tbl[16] = '{1, 0, 1, 0, 32'h55,   32'h0,        1, 0, 0, 32'h100, 32'h5,   0, 0, 32'h0,        1, 0, 32'h0,        32'h0};
    tbl[17] = '{1, 9, 0, 0, 32'h99,   32'h0,        1, 9, 0, 32'h900, 32'h5,   0, 0, 32'h55,       1, 1, 32'h900,      32'h0};
    tbl[18] = '{0, 0, 0, 0, 32'h0,    32'h0,        0, 9, 0, 32'h900, 32'h5,   0, 0, 32'h55,       0, 1, 32'h900,      32'h0};
    tbl[19] = '{0, 0, 0, 0, 32'h0,    32'h0,        0, 9, 0, 32'h900, 32'h5,   0, 9, 32'h99,       1, 1, 32'h900,      32'h0};
    tbl[20] = '{0, 0, 0, 0, 32'h0,    32'h0,        0, 9, 0, 32'h900, 32'h5,   0, 0, 32'h0,        1, 0, 32'h900,      32'h0};

    rst = 1'b1;
    drive(tbl[0]);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < int'(NV); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d we3", i),      32'(bus.we3),      32'(tbl[i].e_we));
      chk($sformatf("v%0d a3", i),       32'(bus.a3),       32'(tbl[i].e_a3));
      chk($sformatf("v%0d wd3", i),      bus.wd3,           tbl[i].e_wd);
      chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d busy", i),     32'(bus.busy),     32'(tbl[i].e_busy));
      chk($sformatf("v%0d fwd_rd1", i),  bus.fwd_rd1,       tbl[i].e_f1);
      chk($sformatf("v%0d fwd_rd2", i),  bus.fwd_rd2,       tbl[i].e_f2);
    end

    // Reset mid-operation: fill with hold=1, then assert rst between edges.
    @(negedge clk);
    drive('{1, 10, 1, 0, 32'hA0, 32'h0, 1, 10, 11, 32'hAAA, 32'hBBB, 0, 0, 0, 0, 0, 0, 0});
    @(negedge clk);
    drive('{1, 11, 1, 0, 32'hB0, 32'h0, 1, 10, 11, 32'hAAA, 32'hBBB, 0, 0, 0, 0, 0, 0, 0});
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("rst full in_ready", 32'(bus.in_ready), 32'h0);
    chk("rst full fwd_rd2",  bus.fwd_rd2,       32'hB0);
    #1;
    rst = 1'b1;
    #1;
    chk("rst in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst we3",      32'(bus.we3),      32'h0);
    chk("rst a3",       32'(bus.a3),       32'h0);
    chk("rst wd3",      bus.wd3,           32'h0);
    chk("rst busy",     32'(bus.busy),     32'h0);
    chk("rst fwd_rd1",  bus.fwd_rd1,       32'hAAA);
    chk("rst fwd_rd2",  bus.fwd_rd2,       32'hBBB);
    @(negedge clk);
    bus.hold = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("post-rst%0d we3", k),     32'(bus.we3),  32'h0);
      chk($sformatf("post-rst%0d busy", k),    32'(bus.busy), 32'h0);
      chk($sformatf("post-rst%0d fwd_rd1", k), bus.fwd_rd1,   32'hAAA);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
